// File: rtl/cipher_iter_pkg.sv
// Shared AES definitions for the iterative cipher core.
// Holds the byte, word and block types, the FSM state encoding, the S-box and
// Rcon tables, and the small GF(2^8) / word helpers used by the round logic
// and the key schedule.
// Byte ordering: word_t[b] is byte b of a word and block_t[c][r] is column c,
// row r. Index 0 sits at the LSB end, so a byte string written MSB-first
// appears byte-reversed in these packed vectors.
package cipher_iter_pkg;

   typedef logic [7:0]            byte_t;
   typedef logic [3:0][7:0]       word_t;
   typedef logic [3:0][3:0][7:0]  block_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam byte_t RCON [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic word_t sub_word(input word_t w);
      word_t r;
      r[0] = SBOX[w[0]];
      r[1] = SBOX[w[1]];
      r[2] = SBOX[w[2]];
      r[3] = SBOX[w[3]];
      return r;
   endfunction

   // Cyclic left rotate by one byte: [a0,a1,a2,a3] -> [a1,a2,a3,a0].
   function automatic word_t rot_word(input word_t w);
      return {w[0], w[3], w[2], w[1]};
   endfunction

endpackage

// File: rtl/cipher_iter_round.sv
// One combinational AES encryption round.
// Ports:
//   state       in   current 4x4 state
//   round_key   in   round key to add
//   last        in   final round: skip MixColumns
//   next_state  out  state after SubBytes, ShiftRows, [MixColumns], AddRoundKey
module cipher_round
   import cipher_iter_pkg::*;
(
   input  block_t state,
   input  block_t round_key,
   input  logic   last,
   output block_t next_state
);

   block_t sr;
   block_t mc;

   for (genvar c = 0; c < 4; c++) begin : g_col
      // SubBytes and ShiftRows fused: row r is rotated left by r columns.
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[c][r] = SBOX[state[(c + r) % 4][r]];
      end

      assign mc[c][0] = xtime(sr[c][0]) ^ xtime(sr[c][1]) ^ sr[c][1] ^ sr[c][2] ^ sr[c][3];
      assign mc[c][1] = sr[c][0] ^ xtime(sr[c][1]) ^ xtime(sr[c][2]) ^ sr[c][2] ^ sr[c][3];
      assign mc[c][2] = sr[c][0] ^ sr[c][1] ^ xtime(sr[c][2]) ^ xtime(sr[c][3]) ^ sr[c][3];
      assign mc[c][3] = xtime(sr[c][0]) ^ sr[c][0] ^ sr[c][1] ^ sr[c][2] ^ xtime(sr[c][3]);
   end

   assign next_state = (last ? sr : mc) ^ round_key;

endmodule

// File: rtl/cipher_iter.sv
// Iterative AES encryption core, one round per clock, key expanded on the fly.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   key        in   cipher key, key[w][b] = key byte 4w+b
//   data       in   plaintext, data[c][r] = input byte 4c+r
//   in_valid   in   key/data offered
//   in_ready   out  block can accept key/data this cycle
//   o          out  ciphertext, same byte order as data
//   out_valid  out  o holds a finished ciphertext
//   out_ready  in   consumer takes o this cycle
//
// state | meaning
// IDLE  | empty, ready for a block
// ROUND | applying rounds 1..Nr, one per cycle
// DONE  | ciphertext held on o until out_ready
module cipher_iter
   import cipher_iter_pkg::*;
#(
   parameter int NK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  word_t [NK-1:0]    key,
   input  block_t            data,
   input  logic              in_valid,
   output logic              in_ready,
   output block_t            o,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [3:0] NR = 4'(NK + 6);

   fsm_t           fsm;
   logic [3:0]     rnd;
   word_t [NK-1:0] kwin;
   word_t [NK-1:0] kwin_next;
   block_t         st;
   block_t         rkey;
   block_t         round_out;
   logic           accept;

   assign in_ready = !rst && ((fsm == IDLE) || ((fsm == DONE) && out_ready));
   assign accept   = in_valid && in_ready;

   if (NK == 4) begin : g_k128
      // Window holds round key r-1; expanding it gives round key r, which is
      // used this cycle and becomes the next window.
      word_t      tw;
      logic [3:0] ridx;
      always_comb begin
         ridx         = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
         tw           = sub_word(rot_word(kwin[3]));
         tw[0]        = tw[0] ^ RCON[ridx];
         kwin_next[0] = kwin[0] ^ tw;
         kwin_next[1] = kwin[1] ^ kwin_next[0];
         kwin_next[2] = kwin[2] ^ kwin_next[1];
         kwin_next[3] = kwin[3] ^ kwin_next[2];
      end
      assign rkey = kwin_next;
   end else begin : g_k256
      // Window holds words 4(r-1)..4r+3; round key r is its upper half.
      // Advancing by four words alternates Rot+Sub+Rcon (odd r) and Sub-only.
      word_t      tw;
      logic [3:0] ridx;
      always_comb begin
         ridx         = {1'b0, rnd[3:1]};
         tw           = sub_word(rnd[0] ? rot_word(kwin[7]) : kwin[7]);
         if (rnd[0]) tw[0] = tw[0] ^ RCON[ridx];
         kwin_next[3:0] = kwin[7:4];
         kwin_next[4] = kwin[0] ^ tw;
         kwin_next[5] = kwin[1] ^ kwin_next[4];
         kwin_next[6] = kwin[2] ^ kwin_next[5];
         kwin_next[7] = kwin[3] ^ kwin_next[6];
      end
      assign rkey = kwin[7:4];
   end

   cipher_round u_round (
      .state      (st),
      .round_key  (rkey),
      .last       (rnd == NR),
      .next_state (round_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= IDLE;
         out_valid <= 1'b0;
         o         <= '0;
         rnd       <= '0;
         kwin      <= '0;
         st        <= '0;
      end else if (accept) begin
         st        <= data ^ key[3:0];
         rnd       <= 4'd1;
         kwin      <= key;
         fsm       <= ROUND;
         out_valid <= 1'b0;
      end else begin
         case (fsm)
            ROUND: begin
               st   <= round_out;
               kwin <= kwin_next;
               if (rnd == NR) begin
                  fsm       <= DONE;
                  o         <= round_out;
                  out_valid <= 1'b1;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  fsm       <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cipher_iter.sv
// Directed bench for cipher_iter: FIPS-197 vectors at NK=4 and NK=8, output
// hold, back-to-back throughput, in_valid ignored mid-block, and reset aborts.
module tb_cipher_iter;
   import cipher_iter_pkg::*;

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   word_t [3:0] key4;
   word_t [7:0] key8;
   block_t      data4, data8, o4, o8;
   logic        iv4, iv8, ir4, ir8, ov4, ov8, or4, or8;

   int checks   = 0;
   int failures = 0;

   cipher_iter #(.NK(4)) u_dut4 (
      .clk(clk), .rst(rst), .key(key4), .data(data4), .in_valid(iv4),
      .in_ready(ir4), .o(o4), .out_valid(ov4), .out_ready(or4)
   );

   cipher_iter #(.NK(8)) u_dut8 (
      .clk(clk), .rst(rst), .key(key8), .data(data8), .in_valid(iv8),
      .in_ready(ir8), .o(o8), .out_valid(ov8), .out_ready(or8)
   );

   // Byte strings are written MSB-first; the packed ports put byte 0 at the LSB.
   function automatic block_t to_blk(input logic [127:0] v);
      block_t b;
      b = {<<8{v}};
      return b;
   endfunction

   function automatic logic [127:0] hex(input block_t b);
      logic [127:0] v;
      v = {<<8{b}};
      return v;
   endfunction

   function automatic word_t [7:0] to_key8(input logic [255:0] v);
      word_t [7:0] k;
      k = {<<8{v}};
      return k;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after the accepting edge; counts edges until out_valid.
   task automatic wait_done(input bit sel8, output int n);
      n = 0;
      @(negedge clk);
      while (((sel8 ? ov8 : ov4) !== 1'b1) && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; iv4 = 1'b0; iv8 = 1'b0; or4 = 1'b0; or8 = 1'b0;
      key4 = '0; key8 = '0; data4 = '0; data8 = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready4", 128'(ir4), 128'(1'b0));
      check("rst_in_ready8", 128'(ir8), 128'(1'b0));
      check("rst_out_valid", 128'(ov4), 128'(1'b0));
      check("rst_o", hex(o4), 128'(0));
      rst = 1'b0;
      #1;
      check("idle_in_ready4", 128'(ir4), 128'(1'b1));
      check("idle_in_ready8", 128'(ir8), 128'(1'b1));

      // FIPS-197 appendix B vector, latency and output hold
      key4 = to_blk(KEY_A); data4 = to_blk(PT_A); iv4 = 1'b1;
      @(posedge clk); #1 iv4 = 1'b0;
      wait_done(1'b0, n);
      check("lat_a", 128'(n), 128'(10));
      check("ct_a", hex(o4), CT_A);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_o", hex(o4), CT_A);
         check("hold_out_valid", 128'(ov4), 128'(1'b1));
         check("hold_in_ready", 128'(ir4), 128'(1'b0));
      end
      or4 = 1'b1;
      #1 check("done_in_ready", 128'(ir4), 128'(1'b1));
      @(negedge clk);
      check("drain_out_valid", 128'(ov4), 128'(1'b0));
      check("drain_in_ready", 128'(ir4), 128'(1'b1));
      or4 = 1'b0;

      // Appendix C.1 vector; in_valid stays high with other data mid-block
      key4 = to_blk(KEY_B); data4 = to_blk(PT_B); iv4 = 1'b1;
      @(posedge clk); #1 key4 = to_blk(KEY_A); data4 = to_blk(PT_A);
      wait_done(1'b0, n);
      check("lat_b", 128'(n), 128'(10));
      check("ct_b", hex(o4), CT_B);
      iv4 = 1'b0; or4 = 1'b1;
      @(negedge clk);
      or4 = 1'b0;

      // AES-256, appendix C.3
      key8 = to_key8(KEY_C); data8 = to_blk(PT_B); iv8 = 1'b1;
      @(posedge clk); #1 iv8 = 1'b0;
      wait_done(1'b1, n);
      check("lat_c", 128'(n), 128'(14));
      check("ct_c", hex(o8), CT_C);
      or8 = 1'b1;
      @(negedge clk);
      check("drain_out_valid8", 128'(ov8), 128'(1'b0));
      or8 = 1'b0;

      // Back-to-back: second block taken on the DONE edge
      or4 = 1'b1; key4 = to_blk(KEY_A); data4 = to_blk(PT_A); iv4 = 1'b1;
      @(posedge clk); #1 key4 = to_blk(KEY_B); data4 = to_blk(PT_B);
      wait_done(1'b0, n);
      check("b2b_lat_first", 128'(n), 128'(10));
      check("b2b_ct_first", hex(o4), CT_A);
      check("b2b_in_ready", 128'(ir4), 128'(1'b1));
      n = 1;
      @(negedge clk);
      check("b2b_gap_out_valid", 128'(ov4), 128'(1'b0));
      iv4 = 1'b0;
      while (ov4 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("b2b_spacing", 128'(n), 128'(11));
      check("b2b_ct_second", hex(o4), CT_B);
      @(negedge clk);
      check("b2b_idle_out_valid", 128'(ov4), 128'(1'b0));
      or4 = 1'b0;

      // Reset mid-block aborts, then a fresh block still encrypts correctly
      key4 = to_blk(KEY_B); data4 = to_blk(PT_B); iv4 = 1'b1;
      @(posedge clk); #1 iv4 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_mid_in_ready", 128'(ir4), 128'(1'b0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_out_valid", 128'(ov4), 128'(1'b0));
      check("abort_o", hex(o4), 128'(0));
      check("abort_in_ready", 128'(ir4), 128'(1'b1));
      key4 = to_blk(KEY_A); data4 = to_blk(PT_A); iv4 = 1'b1;
      @(posedge clk); #1 iv4 = 1'b0;
      wait_done(1'b0, n);
      check("post_rst_lat", 128'(n), 128'(10));
      check("post_rst_ct", hex(o4), CT_A);

      // Reset in DONE overrides in_ready even with out_ready high
      or4 = 1'b1; iv4 = 1'b1; rst = 1'b1;
      #1 check("rst_done_in_ready", 128'(ir4), 128'(1'b0));
      @(negedge clk);
      rst = 1'b0; iv4 = 1'b0; or4 = 1'b0;
      #1;
      check("rst_done_out_valid", 128'(ov4), 128'(1'b0));
      check("rst_done_o", hex(o4), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cipher_iter.md
CIPHER_ITER -- requirements
Module: cipher_iter

Interface
REQ-001 SHALL have parameter NK, default 4, meaning key length in 32-bit words; legal values are 4 (AES-128) and 8 (AES-256); Nr = NK+6 rounds.
REQ-002 SHALL have ports in this order; port list: name  direction  width  meaning.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 key  in  8 x [NK][4]  cipher key; key[w][b] is FIPS-197 key byte 4w+b.
REQ-006 data  in  8 x [4][4]  plaintext block; data[c][r] is FIPS-197 input byte 4c+r.
REQ-007 in_valid  in  1  key/data offered.
REQ-008 in_ready  out  1  block can accept key/data this cycle.
REQ-009 o  out  8 x [4][4]  ciphertext, same byte ordering as data.
REQ-010 out_valid  out  1  o holds a finished ciphertext.
REQ-011 out_ready  in  1  consumer takes o this cycle.

Function
REQ-012 SHALL implement a three-state machine: IDLE, ROUND, DONE.
REQ-013 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise, including any cycle with rst=1.
REQ-014 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1: state <= data XOR round key 0 (key words 0..3), round counter <= 1, key window <= key, FSM -> ROUND.
REQ-015 In ROUND, each cycle SHALL apply one full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) for rounds 1..Nr-1; round Nr SHALL omit MixColumns.
REQ-016 The round key for round r SHALL be words 4r..4r+3 of the FIPS-197 expansion, generated on the fly from the key window; no full schedule storage.
REQ-017 NK=4: each step SHALL derive 4 words using RotWord, SubWord and Rcon. NK=8: steps SHALL alternate RotWord+SubWord+Rcon and SubWord-only. Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
REQ-018 After round Nr, the FSM SHALL move to DONE, update o with the result, and set out_valid=1.
REQ-019 Latency SHALL be exactly Nr cycles from the accepting edge to the first cycle with out_valid=1: 10 for NK=4, 14 for NK=8.
REQ-020 In DONE, o and out_valid SHALL hold stable until out_ready=1.
REQ-021 In DONE with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE and out_valid SHALL drop to 0 next cycle.
REQ-022 In DONE with out_ready=1 and in_valid=1, a new block SHALL be accepted on the same edge (FSM -> ROUND, out_valid -> 0); sustained throughput is one block per Nr+1 cycles.
REQ-023 in_valid during ROUND SHALL be ignored; key and data are sampled only on the accepting edge.
REQ-024 All arithmetic SHALL be in GF(2^8) with polynomial 0x11b; the round counter SHALL be 4 bits wide and never wrap past Nr.

Reset
REQ-025 On any edge with rst=1, the block SHALL set: FSM = IDLE, out_valid = 0, o = all zero, round counter = 0, key window = 0, state = 0.
REQ-026 Reset asserted mid-ROUND or in DONE SHALL abort the operation with no partial output; the next block is accepted no earlier than the first edge with rst=0.

Structure
REQ-027 The shared definitions package SHALL hold: the byte, word and 4x4 block types; the S-box table; the Rcon table; and xtime, SubWord and RotWord functions.
REQ-028 One sub-module, cipher_round, SHALL be combinational: inputs state, round key and a last-round flag; output the next state.
REQ-029 The key schedule SHALL stay inside cipher_iter.

Verification
REQ-030 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> o=3925841d02dc09fbdc118597196a0b32, out_valid rises exactly 10 cycles after accept.
REQ-031 NK=4, key 000102...0f, data 00112233445566778899aabbccddeeff -> o=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 NK=8, key 000102...1f, same data -> o=8ea2b7ca516745bfeafc49904b496089, out_valid rises 14 cycles after accept.
REQ-033 out_ready held 0 for 5 cycles in DONE -> o and out_valid stable; in_ready=0 throughout.
REQ-034 Back-to-back: in_valid and out_ready held 1 with two vectors -> second accepted on the DONE edge, results separated by Nr+1 cycles.
REQ-035 rst pulsed at round 5 -> out_valid=0, o=0, in_ready=1 the cycle after rst falls; a fresh vector then yields the correct ciphertext.
